// File: rtl/hazard_pkg.sv
// Shared definitions for the MIPS hazard unit with mul/div busy tracking.
// Contents:
//   AW_DEFAULT - default register-index width
//   REG_ZERO   - index of the hard-wired zero register
//   fwd_sel_t  - E-stage operand forwarding select encoding
package hazard_pkg;

  localparam int AW_DEFAULT = 5;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,  // operand from the register file
    FWD_WB  = 2'b01,  // operand from the W-stage result
    FWD_MEM = 2'b10   // operand from the M-stage ALU result
  } fwd_sel_t;

endpackage

// File: rtl/md_busy_tracker.sv
// Occupancy tracker for the multi-cycle mul/div unit.
// A mul/div issuing from Execute loads the counter with MD_LAT-1. The counter
// then counts down to zero, and HI/LO are valid again once it reaches zero.
// An issue in the same cycle as a pending decrement always reloads.
// Ports:
//   clk      in  pipeline clock
//   reset_n  in  asynchronous active-low reset (clears the counter)
//   mdstartE in  mul/div issuing from Execute this cycle
//   mdbusy   out counter nonzero (unit still occupied after the issue cycle)
module md_busy_tracker #(
  parameter int MD_LAT = 32
) (
  input  logic clk,
  input  logic reset_n,
  input  logic mdstartE,
  output logic mdbusy
);

  localparam int CW = $clog2(MD_LAT + 1);
  // The issue cycle itself is covered by mdstartE, so only MD_LAT-1
  // further cycles need tracking. With MD_LAT=1 this value is 0.
  localparam logic [CW-1:0] Reload = CW'(MD_LAT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (mdstartE) begin
      cnt <= Reload;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign mdbusy = (cnt != '0);

endmodule

// File: rtl/hazard_unit_md.sv
// Hazard unit for the 5-stage MIPS pipeline: E-stage forwarding from M/W,
// D-stage forwarding for branches resolved in Decode, load-use and branch
// stalls, and stalls for MFHI/MFLO or back-to-back mul/div while the
// multi-cycle mul/div unit is busy.
// Optional feature macro: HAZARD_PERF_EN adds saturating stall counters
//   perf_lw, perf_br, perf_md (PERF_W bits each).
// Ports:
//   clk, reset_n                       clock, async active-low reset
//   rsD, rtD, rsE, rtE                 source registers in D and E
//   writeregE/M/W, regwriteE/M/W       destination and write enable per stage
//   memtoregE, memtoregM               stage holds a load
//   branchD, mdopD, mdreadD            branch / mul-div / MFHI-MFLO in Decode
//   mdstartE                           mul/div issuing from Execute
//   forwardaE, forwardbE               E operand select (fwd_sel_t encoding)
//   forwardaD, forwardbD               D comparator takes the M-stage result
//   stallF, stallD, flushE             hold PC and F/D, bubble into D/E
//   mdbusy                             mul/div unit still occupied
// All outputs are forced to 0 while reset_n is low.
module hazard_unit_md
  import hazard_pkg::*;
#(
  parameter int AW     = AW_DEFAULT,
  parameter int MD_LAT = 32,
  parameter int PERF_W = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] rsD,
  input  logic [AW-1:0] rtD,
  input  logic [AW-1:0] rsE,
  input  logic [AW-1:0] rtE,
  input  logic [AW-1:0] writeregE,
  input  logic [AW-1:0] writeregM,
  input  logic [AW-1:0] writeregW,
  input  logic          regwriteE,
  input  logic          regwriteM,
  input  logic          regwriteW,
  input  logic          memtoregE,
  input  logic          memtoregM,
  input  logic          branchD,
  input  logic          mdopD,
  input  logic          mdreadD,
  input  logic          mdstartE,
  output logic [1:0]    forwardaE,
  output logic [1:0]    forwardbE,
  output logic          forwardaD,
  output logic          forwardbD,
  output logic          stallF,
  output logic          stallD,
  output logic          flushE,
`ifdef HAZARD_PERF_EN
  output logic [PERF_W-1:0] perf_lw,
  output logic [PERF_W-1:0] perf_br,
  output logic [PERF_W-1:0] perf_md,
`endif
  output logic          mdbusy
);

  localparam logic [AW-1:0] Zero = AW'(REG_ZERO);

  // Elaboration-time guard on the configuration.
  if (MD_LAT < 1 || MD_LAT > 255 || PERF_W < 1) begin : gBadParam
    $error("hazard_unit_md: MD_LAT must be 1..255 and PERF_W >= 1");
  end

  // Nonzero destination r is read by the instruction in Decode.
  function automatic logic hitsD(input logic [AW-1:0] r,
                                 input logic [AW-1:0] a,
                                 input logic [AW-1:0] b);
    return (r != Zero) && ((r == a) || (r == b));
  endfunction

  fwd_sel_t fwdA;
  fwd_sel_t fwdB;
  logic     fwdAD;
  logic     fwdBD;
  logic     lwStall;
  logic     brStall;
  logic     mdStall;
  logic     anyStall;
  logic     busyRaw;

  // M has priority over W: it holds the younger write to the same register.
  always_comb begin
    fwdA = FWD_RF;
    fwdB = FWD_RF;
    if (rsE != Zero && regwriteM && writeregM == rsE)      fwdA = FWD_MEM;
    else if (rsE != Zero && regwriteW && writeregW == rsE) fwdA = FWD_WB;
    if (rtE != Zero && regwriteM && writeregM == rtE)      fwdB = FWD_MEM;
    else if (rtE != Zero && regwriteW && writeregW == rtE) fwdB = FWD_WB;
  end

  assign fwdAD = (rsD != Zero) && regwriteM && (writeregM == rsD);
  assign fwdBD = (rtD != Zero) && regwriteM && (writeregM == rtD);

  assign lwStall = memtoregE && regwriteE && hitsD(writeregE, rsD, rtD);
  // A branch compares in Decode, so it must wait for any ALU result still in
  // Execute and for any load still in Memory.
  assign brStall = branchD &&
                   ((regwriteE && hitsD(writeregE, rsD, rtD)) ||
                    (memtoregM && hitsD(writeregM, rsD, rtD)));
  // The issue cycle itself stalls: the counter is only loaded at its end.
  assign mdStall = (mdreadD || mdopD) && (busyRaw || mdstartE);
  assign anyStall = lwStall || brStall || mdStall;

  md_busy_tracker #(
    .MD_LAT(MD_LAT)
  ) uTracker (
    .clk     (clk),
    .reset_n (reset_n),
    .mdstartE(mdstartE),
    .mdbusy  (busyRaw)
  );

  assign forwardaE = reset_n ? fwdA : FWD_RF;
  assign forwardbE = reset_n ? fwdB : FWD_RF;
  assign forwardaD = reset_n && fwdAD;
  assign forwardbD = reset_n && fwdBD;
  assign stallF    = reset_n && anyStall;
  assign stallD    = reset_n && anyStall;
  assign flushE    = reset_n && anyStall;
  assign mdbusy    = reset_n && busyRaw;

`ifdef HAZARD_PERF_EN
  localparam logic [PERF_W-1:0] PerfMax = '1;

  // Each term counts independently, so overlapping stalls bump several.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_lw <= '0;
      perf_br <= '0;
      perf_md <= '0;
    end else begin
      if (lwStall && perf_lw != PerfMax) perf_lw <= perf_lw + PERF_W'(1);
      if (brStall && perf_br != PerfMax) perf_br <= perf_br + PERF_W'(1);
      if (mdStall && perf_md != PerfMax) perf_md <= perf_md + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_unit_md.sv
// Bench for hazard_unit_md. Two instances share one stimulus: one with
// MD_LAT=4 and one with MD_LAT=1. Inputs change on the falling edge,
// outputs are checked 1 ns before the rising edge against a model that
// derives mul/div occupancy from the cycle number of the latest issue.
module tb_hazard_unit_md;

  localparam int AW     = 5;
  localparam int LAT    = 4;
  localparam int PERF_W = 4;
  localparam int PMAX   = (1 << PERF_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset_n;

  logic [AW-1:0] rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
  logic regwriteE, regwriteM, regwriteW, memtoregE, memtoregM;
  logic branchD, mdopD, mdreadD, mdstartE;

  logic [1:0] forwardaE, forwardbE;
  logic forwardaD, forwardbD, stallF, stallD, flushE, mdbusy;
  logic [1:0] forwardaE1, forwardbE1;
  logic forwardaD1, forwardbD1, stallF1, stallD1, flushE1, mdbusy1;
`ifdef HAZARD_PERF_EN
  logic [PERF_W-1:0] perf_lw, perf_br, perf_md;
  logic [PERF_W-1:0] perf_lw1, perf_br1, perf_md1;
`endif

  hazard_unit_md #(.AW(AW), .MD_LAT(LAT), .PERF_W(PERF_W)) dut (
    .clk(clk), .reset_n(reset_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
    .mdopD(mdopD), .mdreadD(mdreadD), .mdstartE(mdstartE),
    .forwardaE(forwardaE), .forwardbE(forwardbE),
    .forwardaD(forwardaD), .forwardbD(forwardbD),
    .stallF(stallF), .stallD(stallD), .flushE(flushE),
`ifdef HAZARD_PERF_EN
    .perf_lw(perf_lw), .perf_br(perf_br), .perf_md(perf_md),
`endif
    .mdbusy(mdbusy)
  );

  hazard_unit_md #(.AW(AW), .MD_LAT(1), .PERF_W(PERF_W)) dut1 (
    .clk(clk), .reset_n(reset_n), .rsD(rsD), .rtD(rtD), .rsE(rsE), .rtE(rtE),
    .writeregE(writeregE), .writeregM(writeregM), .writeregW(writeregW),
    .regwriteE(regwriteE), .regwriteM(regwriteM), .regwriteW(regwriteW),
    .memtoregE(memtoregE), .memtoregM(memtoregM), .branchD(branchD),
    .mdopD(mdopD), .mdreadD(mdreadD), .mdstartE(mdstartE),
    .forwardaE(forwardaE1), .forwardbE(forwardbE1),
    .forwardaD(forwardaD1), .forwardbD(forwardbD1),
    .stallF(stallF1), .stallD(stallD1), .flushE(flushE1),
`ifdef HAZARD_PERF_EN
    .perf_lw(perf_lw1), .perf_br(perf_br1), .perf_md(perf_md1),
`endif
    .mdbusy(mdbusy1)
  );

  // ---------------- scoreboard state ----------------
  int testsRun  = 0;
  int failCount = 0;
  int cycleNo   = 0;
  int issueQ[$];          // cycle numbers of mul/div issues since reset
  int expLw = 0, expBr = 0, expMd = 0;
  bit allowRestart = 1'b0;

  // A restart while busy is illegal in a real pipeline; only the directed
  // reload test creates one on purpose.
  always @(posedge clk) begin
    if (reset_n && !allowRestart)
      assert (!(mdstartE && mdbusy)) else $error("mul/div restart while busy");
  end

  task automatic checkVal(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    testsRun++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycleNo);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit isMatch(input logic [AW-1:0] r);
    return r != 0 && (r == rsD || r == rtD);
  endfunction

  function automatic logic [1:0] refFwdE(input logic [AW-1:0] src);
    if (src == 0) return 2'b00;
    if (regwriteM && writeregM == src) return 2'b10;
    if (regwriteW && writeregW == src) return 2'b01;
    return 2'b00;
  endfunction

  // Busy in the lat-1 cycles that follow the most recent issue.
  function automatic bit refBusy(input int lat);
    int d;
    if (issueQ.size() == 0) return 1'b0;
    d = cycleNo - issueQ[$];
    return d >= 1 && d <= lat - 1;
  endfunction

  function automatic bit refLw();
    return memtoregE && regwriteE && isMatch(writeregE);
  endfunction

  function automatic bit refBr();
    return branchD && ((regwriteE && isMatch(writeregE)) ||
                       (memtoregM && isMatch(writeregM)));
  endfunction

  function automatic bit refMd(input int lat);
    return (mdreadD || mdopD) && (refBusy(lat) || mdstartE);
  endfunction

  task automatic checkAll(input string ctx);
    bit r;
    bit st, st1;
    r   = reset_n;
    st  = r && (refLw() || refBr() || refMd(LAT));
    st1 = r && (refLw() || refBr() || refMd(1));
    checkVal({ctx, ".faE"}, 32'(forwardaE), r ? 32'(refFwdE(rsE)) : 32'd0);
    checkVal({ctx, ".fbE"}, 32'(forwardbE), r ? 32'(refFwdE(rtE)) : 32'd0);
    checkVal({ctx, ".faD"}, 32'(forwardaD),
             32'(r && rsD != 0 && regwriteM && writeregM == rsD));
    checkVal({ctx, ".fbD"}, 32'(forwardbD),
             32'(r && rtD != 0 && regwriteM && writeregM == rtD));
    checkVal({ctx, ".stallF"}, 32'(stallF), 32'(st));
    checkVal({ctx, ".stallD"}, 32'(stallD), 32'(st));
    checkVal({ctx, ".flushE"}, 32'(flushE), 32'(st));
    checkVal({ctx, ".mdbusy"}, 32'(mdbusy), 32'(r && refBusy(LAT)));
    checkVal({ctx, ".stallF1"}, 32'(stallF1), 32'(st1));
    checkVal({ctx, ".mdbusy1"}, 32'(mdbusy1), 32'(r && refBusy(1)));
`ifdef HAZARD_PERF_EN
    checkVal({ctx, ".perfLw"}, 32'(perf_lw), 32'(expLw));
    checkVal({ctx, ".perfBr"}, 32'(perf_br), 32'(expBr));
    checkVal({ctx, ".perfMd"}, 32'(perf_md), 32'(expMd));
`endif
  endtask

  // ---------------- driver tasks ----------------
  // Entered on a falling edge with inputs already applied.
  task automatic cycle(input string ctx);
    #4;
    checkAll(ctx);
    @(posedge clk);
    if (reset_n) begin
      if (refLw() && expLw < PMAX) expLw++;
      if (refBr() && expBr < PMAX) expBr++;
      if (refMd(LAT) && expMd < PMAX) expMd++;
      if (mdstartE) issueQ.push_back(cycleNo);
    end
    cycleNo++;
    @(negedge clk);
  endtask

  task automatic clearInputs();
    rsD = '0; rtD = '0; rsE = '0; rtE = '0;
    writeregE = '0; writeregM = '0; writeregW = '0;
    regwriteE = 0; regwriteM = 0; regwriteW = 0;
    memtoregE = 0; memtoregM = 0;
    branchD = 0; mdopD = 0; mdreadD = 0; mdstartE = 0;
  endtask

  task automatic modelReset();
    issueQ.delete();
    expLw = 0; expBr = 0; expMd = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clearInputs();
    reset_n = 1'b0;
    @(negedge clk);
    // Hazardous inputs while in reset: everything must still read 0.
    rsE = 5'd8; rtE = 5'd8; regwriteM = 1; writeregM = 5'd8;
    memtoregE = 1; regwriteE = 1; writeregE = 5'd8; rsD = 5'd8; mdreadD = 1;
    mdstartE = 1;
    cycle("inReset");
    clearInputs();
    reset_n = 1'b1;
    cycle("idle");

    // E-stage forwarding: M wins, then W, then register 0 never forwards.
    rsE = 5'd8; rtE = 5'd8; regwriteM = 1; writeregM = 5'd8;
    regwriteW = 1; writeregW = 5'd8;
    cycle("fwdM");
    writeregM = 5'd9;
    cycle("fwdW");
    rsE = 5'd0; rtE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
    cycle("fwdZero");
    clearInputs();

    // Load-use stall for one cycle, none when the load targets register 0.
    memtoregE = 1; regwriteE = 1; writeregE = 5'd5; rtD = 5'd5;
    cycle("lw");
    clearInputs();
    cycle("lwAfter");
    memtoregE = 1; regwriteE = 1; writeregE = 5'd0; rtD = 5'd0;
    cycle("lwZero");
    clearInputs();

    // Branch waits on a load in M, then gets the M result forwarded.
    branchD = 1; rsD = 5'd4; memtoregM = 1; regwriteM = 1; writeregM = 5'd4;
    cycle("brLoadM");
    memtoregM = 0;
    cycle("brFwdD");
    clearInputs();

    // MFHI held from the issue cycle: stalls LAT cycles.
    mdstartE = 1; mdreadD = 1;
    cycle("mdIssue");
    mdstartE = 0;
    for (int i = 0; i < LAT + 1; i++) cycle("mdWait");
    clearInputs();

    // Reload at the cnt==1 decrement: the new occupancy window wins.
    allowRestart = 1'b1;
    mdstartE = 1;
    cycle("reload0");
    mdstartE = 0;
    cycle("reload1");
    cycle("reload2");
    mdstartE = 1; mdopD = 1;
    cycle("reloadHit");
    mdstartE = 0;
    for (int i = 0; i < LAT; i++) cycle("reloadWait");
    allowRestart = 1'b0;
    clearInputs();

    // Asynchronous reset with two cycles of occupancy left.
    mdstartE = 1;
    cycle("rstIssue");
    mdstartE = 0;
    cycle("rstCnt3");
    rsE = 5'd7; regwriteM = 1; writeregM = 5'd7; mdreadD = 1;
    #2 reset_n = 1'b0;
    modelReset();
    #1 checkAll("rstAsync");
    @(negedge clk);
    cycle("rstHold");
    reset_n = 1'b1;
    clearInputs();
    mdreadD = 1;
    cycle("rstRelease");
    clearInputs();

    // Load-use held long enough to saturate the narrow counter.
    memtoregE = 1; regwriteE = 1; writeregE = 5'd5; rtD = 5'd5;
    for (int i = 0; i < 20; i++) cycle("lwHold");
    clearInputs();
    cycle("lwHoldEnd");

    // Randomized traffic over a small register window to force collisions.
    for (int i = 0; i < 400; i++) begin
      rsD = AW'($urandom_range(0, 3)); rtD = AW'($urandom_range(0, 3));
      rsE = AW'($urandom_range(0, 3)); rtE = AW'($urandom_range(0, 3));
      writeregE = AW'($urandom_range(0, 3));
      writeregM = AW'($urandom_range(0, 3));
      writeregW = AW'($urandom_range(0, 3));
      regwriteE = 1'($urandom_range(0, 1));
      regwriteM = 1'($urandom_range(0, 1));
      regwriteW = 1'($urandom_range(0, 1));
      memtoregE = 1'($urandom_range(0, 1));
      memtoregM = 1'($urandom_range(0, 1));
      branchD   = 1'($urandom_range(0, 1));
      mdopD     = ($urandom_range(0, 3) == 0);
      mdreadD   = ($urandom_range(0, 3) == 0);
      mdstartE  = !refBusy(LAT) && ($urandom_range(0, 4) == 0);
      cycle("rand");
    end
    clearInputs();
    cycle("final");

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
